riscvlong_inst_unpack_pipe: RTL and testbench

Parametrised, pipelined instruction-field unpacker for the riscvlong front end. It accepts a bundle of 1–4 raw 32-bit RISC-V instructions over a val/rdy handshake and classifies each lane's format (R/I/S/SB/U/UJ/illegal). For each lane it extracts the register and function fields and the sign-extended immediate at XLEN width. Decoded bundles are buffered in a small FIFO before handoff to issue, and a wrapping count of legally decoded instructions is kept.

---
 rtl/riscvlong_inst_unpack_pipe_if.sv | 38 +++
 rtl/riscvlong_inst_unpack_pipe.sv | 173 +++++++++++++++++
 tb/tb_riscvlong_inst_unpack_pipe.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscvlong_inst_unpack_pipe_if.sv
// Handshake bundle between the front end, the field unpacker and issue.
// The unpacker takes the slave side; producer/consumer logic takes master.
interface riscvlong_inst_unpack_pipe_if #(
    parameter int NLANES = 1,
    parameter int XLEN   = 32
);
    logic                     in_val;
    logic                     in_rdy;
    logic [NLANES*32-1:0]     in_msg;
    logic [NLANES-1:0]        in_mask;

    logic                     out_val;
    logic                     out_rdy;
    logic [NLANES-1:0]        out_lane_val;
    logic [NLANES*3-1:0]      out_fmt;
    logic [NLANES*7-1:0]      out_opcode;
    logic [NLANES*5-1:0]      out_rd;
    logic [NLANES*5-1:0]      out_rs1;
    logic [NLANES*5-1:0]      out_rs2;
    logic [NLANES*3-1:0]      out_funct3;
    logic [NLANES*7-1:0]      out_funct7;
    logic [NLANES*XLEN-1:0]   out_imm;
    logic [31:0]              num_decoded;

    modport master (
        output in_val, in_msg, in_mask, out_rdy,
        input  in_rdy, out_val, out_lane_val, out_fmt, out_opcode,
        input  out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
        input  out_imm, num_decoded
    );

    modport slave (
        input  in_val, in_msg, in_mask, out_rdy,
        output in_rdy, out_val, out_lane_val, out_fmt, out_opcode,
        output out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
        output out_imm, num_decoded
    );
endinterface

// File: rtl/riscvlong_inst_unpack_pipe.sv
// Multi-lane RISC-V instruction field unpacker with a decoded-bundle FIFO
// and a wrapping count of legally decoded, unmasked lanes.
module riscvlong_inst_unpack_pipe #(
    parameter int NLANES = 1,
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2
) (
    input  logic clk,
    input  logic reset_n,
    riscvlong_inst_unpack_pipe_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        F_R   = 3'd0,
        F_I   = 3'd1,
        F_S   = 3'd2,
        F_SB  = 3'd3,
        F_U   = 3'd4,
        F_UJ  = 3'd5,
        F_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        fmt_e            fmt;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
    } lane_t;

    typedef struct packed {
        logic [NLANES-1:0]        lane_val;
        lane_t [NLANES-1:0]       lane;
    } entry_t;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        f = F_ILL;
        case (op)
            7'b0110011: f = F_R;
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011: f = F_I;
            7'b0100011: f = F_S;
            7'b1100011: f = F_SB;
            7'b0110111,
            7'b0010111: f = F_U;
            7'b1101111: f = F_UJ;
            default:    f = F_ILL;
        endcase
        return f;
    endfunction

    function automatic lane_t decode(input logic [31:0] inst);
        lane_t      d;
        logic [31:0] imm32;
        d.fmt    = fmt_of(inst[6:0]);
        d.opcode = inst[6:0];
        d.rd     = inst[11:7];
        d.funct3 = inst[14:12];
        d.rs1    = inst[19:15];
        d.rs2    = inst[24:20];
        d.funct7 = inst[31:25];
        imm32    = '0;
        case (d.fmt)
            F_I:  imm32 = {{20{inst[31]}}, inst[31:20]};
            F_S:  imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            F_SB: imm32 = {{20{inst[31]}}, inst[7], inst[30:25],
                           inst[11:8], 1'b0};
            F_U:  imm32 = {inst[31:12], 12'b0};
            F_UJ: imm32 = {{12{inst[31]}}, inst[19:12], inst[20],
                           inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Widen through 64 bits so one expression serves XLEN 32 and 64.
        d.imm = XLEN'({{32{imm32[31]}}, imm32});
        return d;
    endfunction

    entry_t            dec;
    logic [2:0]        n_legal;
    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [31:0]       num_q;
    logic              enq;
    logic              deq;
    logic              rdy;
    logic              val;

    always_comb begin
        dec          = '0;
        n_legal      = '0;
        dec.lane_val = bus.in_mask;
        for (int i = 0; i < NLANES; i++) begin
            dec.lane[i] = decode(bus.in_msg[32*i +: 32]);
            if (bus.in_mask[i] && dec.lane[i].fmt != F_ILL)
                n_legal = n_legal + 3'd1;
        end
    end

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on occupancy, so a full FIFO never enqueues
    // in the same cycle it dequeues.
    assign rdy = (count < CW'(DEPTH));
    assign val = (count != '0);
    assign enq = bus.in_val && rdy;
    assign deq = val && bus.out_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            num_q <= '0;
        end else begin
            if (enq)
                wptr <= nxt(wptr);
            if (deq)
                rptr <= nxt(rptr);
            if (enq && !deq)
                count <= count + 1'b1;
            else if (deq && !enq)
                count <= count - 1'b1;
            if (enq)
                num_q <= num_q + 32'(n_legal);
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[wptr] <= dec;
    end

    assign head = val ? mem[rptr] : '0;

    always_comb begin
        bus.out_fmt    = '0;
        bus.out_opcode = '0;
        bus.out_rd     = '0;
        bus.out_rs1    = '0;
        bus.out_rs2    = '0;
        bus.out_funct3 = '0;
        bus.out_funct7 = '0;
        bus.out_imm    = '0;
        for (int i = 0; i < NLANES; i++) begin
            bus.out_fmt[3*i +: 3]       = head.lane[i].fmt;
            bus.out_opcode[7*i +: 7]    = head.lane[i].opcode;
            bus.out_rd[5*i +: 5]        = head.lane[i].rd;
            bus.out_rs1[5*i +: 5]       = head.lane[i].rs1;
            bus.out_rs2[5*i +: 5]       = head.lane[i].rs2;
            bus.out_funct3[3*i +: 3]    = head.lane[i].funct3;
            bus.out_funct7[7*i +: 7]    = head.lane[i].funct7;
            bus.out_imm[XLEN*i +: XLEN] = head.lane[i].imm;
        end
    end

    assign bus.in_rdy       = rdy;
    assign bus.out_val      = val;
    assign bus.out_lane_val = head.lane_val;
    assign bus.num_decoded  = num_q;
endmodule

// File: tb/tb_riscvlong_inst_unpack_pipe.sv
// Bench for riscvlong_inst_unpack_pipe: directed bundles plus random
// traffic against a queue-based reference of the decoded-bundle FIFO.
module tb_riscvlong_inst_unpack_pipe;
    localparam int NL = 4;
    localparam int XL = 64;
    localparam int D  = 2;

    typedef struct {
        logic [NL-1:0]    lv;
        logic [NL*3-1:0]  fmt;
        logic [NL*7-1:0]  op;
        logic [NL*5-1:0]  rd;
        logic [NL*5-1:0]  rs1;
        logic [NL*5-1:0]  rs2;
        logic [NL*3-1:0]  f3;
        logic [NL*7-1:0]  f7;
        logic [NL*XL-1:0] imm;
        int               legal;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    exp_t q[$];
    logic [31:0] mnum;

    riscvlong_inst_unpack_pipe_if #(.NLANES(NL), .XLEN(XL)) bus ();

    riscvlong_inst_unpack_pipe #(.NLANES(NL), .XLEN(XL), .DEPTH(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_fmt(input logic [31:0] inst);
        case (inst[6:0])
            7'h33:                    return 0;
            7'h13, 7'h03, 7'h67, 7'h73: return 1;
            7'h23:                    return 2;
            7'h63:                    return 3;
            7'h37, 7'h17:             return 4;
            7'h6F:                    return 5;
            default:                  return 7;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] inst);
        longint s;
        s = longint'($signed(inst));
        case (ref_fmt(inst))
            1: return s >>> 20;
            2: return ((s >>> 25) <<< 5) | longint'(inst[11:7]);
            3: return ((s >>> 31) <<< 12) | (longint'(inst[7]) << 11)
                    | (longint'(inst[30:25]) << 5)
                    | (longint'(inst[11:8]) << 1);
            4: return s & -longint'(4096);
            5: return ((s >>> 31) <<< 20) | (longint'(inst[19:12]) << 12)
                    | (longint'(inst[20]) << 11)
                    | (longint'(inst[30:21]) << 1);
            default: return 64'd0;
        endcase
    endfunction

    function automatic exp_t model(input logic [NL*32-1:0] msg,
                                   input logic [NL-1:0] mask);
        exp_t e;
        logic [31:0] w;
        e.lv = mask;
        e.legal = 0;
        for (int i = 0; i < NL; i++) begin
            w = msg[32*i +: 32];
            e.fmt[3*i +: 3]  = 3'(ref_fmt(w));
            e.op[7*i +: 7]   = w[6:0];
            e.rd[5*i +: 5]   = w[11:7];
            e.f3[3*i +: 3]   = w[14:12];
            e.rs1[5*i +: 5]  = w[19:15];
            e.rs2[5*i +: 5]  = w[24:20];
            e.f7[7*i +: 7]   = w[31:25];
            e.imm[XL*i +: XL] = ref_imm(w);
            if (mask[i] && ref_fmt(w) != 7)
                e.legal++;
        end
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.lv = '0; e.fmt = '0; e.op = '0; e.rd = '0; e.rs1 = '0;
        e.rs2 = '0; e.f3 = '0; e.f7 = '0; e.imm = '0; e.legal = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        exp_t h;
        h = (q.size() != 0) ? q[0] : zero_exp();
        chk("out_val", 256'(bus.out_val), 256'(q.size() != 0));
        chk("in_rdy", 256'(bus.in_rdy), 256'(q.size() < D));
        chk("num_decoded", 256'(bus.num_decoded), 256'(mnum));
        chk("lane_val", 256'(bus.out_lane_val), 256'(h.lv));
        chk("fmt", 256'(bus.out_fmt), 256'(h.fmt));
        chk("opcode", 256'(bus.out_opcode), 256'(h.op));
        chk("rd", 256'(bus.out_rd), 256'(h.rd));
        chk("rs1", 256'(bus.out_rs1), 256'(h.rs1));
        chk("rs2", 256'(bus.out_rs2), 256'(h.rs2));
        chk("funct3", 256'(bus.out_funct3), 256'(h.f3));
        chk("funct7", 256'(bus.out_funct7), 256'(h.f7));
        chk("imm", 256'(bus.out_imm), 256'(h.imm));
    endtask

    // Called at a negedge: check state, drive, take one edge, update model.
    task automatic cyc(input bit v, input logic [NL*32-1:0] msg,
                       input logic [NL-1:0] mask, input bit rdy);
        exp_t e;
        bit   enq;
        bit   deq;
        compare_all();
        bus.in_val  = v;
        bus.in_msg  = msg;
        bus.in_mask = mask;
        bus.out_rdy = rdy;
        e   = model(msg, mask);
        enq = v && (q.size() < D);
        deq = (q.size() != 0) && rdy;
        @(posedge clk);
        if (deq) void'(q.pop_front());
        if (enq) begin
            q.push_back(e);
            mnum = mnum + 32'(e.legal);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [10];
        logic [31:0] r;
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        r = $urandom();
        k = $urandom_range(0, 10);
        if (k == 10) return r;
        return {r[31:7], ops[k]};
    endfunction

    logic [NL*32-1:0] b1, b2, b3, rm;

    initial begin
        checks   = 0;
        failures = 0;
        mnum     = '0;
        reset_n  = 1'b0;
        bus.in_val  = 1'b0;
        bus.in_msg  = '0;
        bus.in_mask = '0;
        bus.out_rdy = 1'b0;
        b1 = {32'h003000B3, 32'hDEADB8B7, 32'h0000007F, 32'h8AD98793};
        b2 = {32'h0000006F, 32'hFE000EE3, 32'h00000013, 32'h00000F33};
        b3 = {32'h00008067, 32'h00000073, 32'h800000EF, 32'h00112023};

        #1;
        chk("rst_out_val", 256'(bus.out_val), 256'(0));
        chk("rst_in_rdy", 256'(bus.in_rdy), 256'(1));
        chk("rst_num", 256'(bus.num_decoded), 256'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        cyc(1'b1, b1, 4'b1011, 1'b0);
        chk("b1_fmt", 256'(bus.out_fmt), 256'(12'b000_100_111_001));
        chk("b1_lv", 256'(bus.out_lane_val), 256'(4'b1011));
        chk("b1_rd0", 256'(bus.out_rd[4:0]), 256'(15));
        chk("b1_rs1_0", 256'(bus.out_rs1[4:0]), 256'(19));
        chk("b1_f3_0", 256'(bus.out_funct3[2:0]), 256'(0));
        chk("b1_imm0", 256'(bus.out_imm[63:0]),
            256'(64'hFFFF_FFFF_FFFF_F8AD));
        chk("b1_rd2", 256'(bus.out_rd[14:10]), 256'(17));
        chk("b1_imm2", 256'(bus.out_imm[191:128]),
            256'(64'hFFFF_FFFF_DEAD_B000));
        chk("b1_imm3", 256'(bus.out_imm[255:192]), 256'(0));
        chk("b1_num", 256'(bus.num_decoded), 256'(2));

        cyc(1'b1, b2, 4'b1111, 1'b0);
        chk("full_in_rdy", 256'(bus.in_rdy), 256'(0));
        cyc(1'b1, b3, 4'b0110, 1'b0);
        cyc(1'b1, b3, 4'b0110, 1'b1);
        chk("deq_no_enq_b2_fmt0", 256'(bus.out_fmt[2:0]), 256'(0));
        chk("deq_no_enq_b2_imm0", 256'(bus.out_imm[63:0]), 256'(0));
        chk("deq_no_enq_rdy", 256'(bus.in_rdy), 256'(1));
        cyc(1'b1, b3, 4'b0110, 1'b0);
        cyc(1'b0, b3, 4'b0000, 1'b1);
        chk("b3_lv", 256'(bus.out_lane_val), 256'(4'b0110));
        cyc(1'b0, b3, 4'b0000, 1'b1);
        cyc(1'b0, b3, 4'b0000, 1'b1);

        force dut.num_q = 32'hFFFF_FFFF;
        #1;
        release dut.num_q;
        mnum = 32'hFFFF_FFFF;
        @(negedge clk);
        cyc(1'b1, b1, 4'b0101, 1'b1);
        chk("wrap_num", 256'(bus.num_decoded), 256'(1));
        cyc(1'b0, b1, 4'b0000, 1'b1);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NL; i++)
                rm[32*i +: 32] = rand_inst();
            cyc(($urandom() % 4) != 0, rm, 4'($urandom()),
                ($urandom() % 2) != 0);
        end
        for (int n = 0; n < 3; n++)
            cyc(1'b0, rm, 4'b0000, 1'b1);

        cyc(1'b1, b1, 4'b1111, 1'b0);
        cyc(1'b1, b2, 4'b1111, 1'b0);
        bus.in_val = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_val", 256'(bus.out_val), 256'(0));
        chk("arst_in_rdy", 256'(bus.in_rdy), 256'(1));
        chk("arst_num", 256'(bus.num_decoded), 256'(0));
        chk("arst_imm", 256'(bus.out_imm), 256'(0));
        q.delete();
        mnum = '0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, b2, 4'b0001, 1'b0);
        chk("post_rst_val", 256'(bus.out_val), 256'(1));
        cyc(1'b0, b2, 4'b0000, 1'b1);
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
